// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and flush support.
// Optional MADD/MSUB accumulate ops (op 6/7) are enabled by defining MDU_MADD_EN.
module mdu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {K_SET, K_ADD, K_SUB} kind_e;

  state_e               state_q;
  kind_e                kind_q, kind_d;
  logic [CW-1:0]        cnt_q, cyc_d;
  logic [2*WIDTH-1:0]   pend_q, res_d, commit_d;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q, launch_d;

  logic [2*WIDTH-1:0]      prod_s, prod_u;
  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0]        sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic [WIDTH-1:0]        min_val;

  assign sa      = a;
  assign sb      = b;
  assign min_val = {1'b1, {(WIDTH-1){1'b0}}};

  // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    sdiv_q = '1;
    sdiv_r = a;
    udiv_q = '1;
    udiv_r = a;
    if (b != '0) begin
      udiv_q = a / b;
      udiv_r = a % b;
      if (a == min_val && b == '1) begin
        sdiv_q = min_val;
        sdiv_r = '0;
      end else begin
        sdiv_q = sa / sb;
        sdiv_r = sa % sb;
      end
    end
  end

  always_comb begin
    launch_d = 1'b0;
    cyc_d    = '0;
    res_d    = '0;
    kind_d   = K_SET;
    case (op)
      3'd0: begin launch_d = 1'b1; cyc_d = CW'(MULT_CYCLES); res_d = prod_s; end
      3'd1: begin launch_d = 1'b1; cyc_d = CW'(MULT_CYCLES); res_d = prod_u; end
      3'd2: begin launch_d = 1'b1; cyc_d = CW'(DIV_CYCLES); res_d = {sdiv_r, sdiv_q}; end
      3'd3: begin launch_d = 1'b1; cyc_d = CW'(DIV_CYCLES); res_d = {udiv_r, udiv_q}; end
`ifdef MDU_MADD_EN
      3'd6: begin launch_d = 1'b1; cyc_d = CW'(MULT_CYCLES); res_d = prod_s; kind_d = K_ADD; end
      3'd7: begin launch_d = 1'b1; cyc_d = CW'(MULT_CYCLES); res_d = prod_s; kind_d = K_SUB; end
`endif
      default: ;
    endcase
  end

  // Accumulate ops read HI/LO as they stand at the commit edge, not at accept.
  always_comb begin
    case (kind_q)
      K_ADD:   commit_d = {hi_q, lo_q} + pend_q;
      K_SUB:   commit_d = {hi_q, lo_q} - pend_q;
      default: commit_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_SET;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            if (launch_d) begin
              state_q <= S_RUN;
              cnt_q   <= cyc_d;
              pend_q  <= res_d;
              kind_q  <= kind_d;
            end else if (op == 3'd4) begin
              hi_q <= a;
            end else if (op == 3'd5) begin
              lo_q <= a;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            done_q       <= 1'b1;
            {hi_q, lo_q} <= commit_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed vector table, corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_mdu_multicycle;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset_n, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions of each op.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint          ps;
    longint unsigned pu;
    int              sx, sy;
    nh = mhi; nl = mlo; lat = 0;
    ps = longint'($signed(x)) * longint'($signed(y));
    pu = {32'h0, x} * {32'h0, y};
    sx = x; sy = y;
    case (o)
      3'd0: begin {nh, nl} = ps; lat = MC; end
      3'd1: begin {nh, nl} = pu; lat = MC; end
      3'd2: begin
        lat = DC;
        if (y == 0) begin nh = x; nl = '1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin nh = 0; nl = x; end
        else begin nl = sx / sy; nh = sx % sy; end
      end
      3'd3: begin
        lat = DC;
        if (y == 0) begin nh = x; nl = '1; end
        else begin nl = x / y; nh = x % y; end
      end
      3'd4: nh = x;
      3'd5: nl = x;
`ifdef MDU_MADD_EN
      3'd6: begin {nh, nl} = {mhi, mlo} + ps; lat = MC; end
      3'd7: begin {nh, nl} = {mhi, mlo} - ps; lat = MC; end
`endif
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int elat);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    if (elat == 0) begin
      chk("imm_busy", busy, 0);
      chk("imm_done", done, 0);
      chk("imm_hi", hi, eh);
      chk("imm_lo", lo, el);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("latency", n, elat);
      chk("done_at_commit", done, 1);
      chk("hi", hi, eh);
      chk("lo", lo, el);
    end
    mhi = eh; mlo = el;
  endtask

  task automatic run_model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int lat;
    model(o, x, y, eh, el, lat);
    run_op(o, x, y, eh, el, lat);
  endtask

  // Flush during the k-th busy cycle; k equal to latency hits the commit edge.
  task automatic flush_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int k);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, mhi);
    chk("flush_lo", lo, mlo);
    @(negedge clk);
    chk("flush_done_after", done, 0);
    chk("flush_hi_after", hi, mhi);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  vec_t vt [8];
  int   n;

  initial begin
    vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vt[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MC};
    vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vt[3] = '{3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DC};
    vt[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC};
    vt[5] = '{3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DC};
    vt[6] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DC};
    vt[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MC};

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].lat);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Reset asserted mid-DIV must clear immediately, without waiting for a clock.
    op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1; mhi = '0; mlo = '0;
    repeat (DC + 2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_hi", hi, 0);

    run_op(3'd4, 32'h1234, 32'h0, 32'h1234, 32'h0, 0);
    run_op(3'd5, 32'hCAFE_0001, 32'h0, 32'h1234, 32'hCAFE_0001, 0);

    // Starts while busy (MTHI then MULT) must be dropped entirely.
    op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 0) begin start = 1'b1; op = 3'd4; a = 32'hDEAD; end
      else if (n == 1) begin op = 3'd0; a = 32'd3; b = 32'd3; end
      else start = 1'b0;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_start_latency", n, DC);
    chk("busy_start_hi", hi, 32'd2);
    chk("busy_start_lo", lo, 32'd14);
    mhi = 32'd2; mlo = 32'd14;

    flush_op(3'd0, 32'd9, 32'd9, 3);
    flush_op(3'd2, 32'd50, 32'd3, DC);
    flush_op(3'd1, 32'hFFFF_FFFF, 32'd2, MC);

    // Flush together with start: flush wins, even for MTHI.
    op = 3'd4; a = 32'h5555; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    op = 3'd0; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_hi", hi, mhi);
    chk("flush_start_busy", busy, 0);
    @(negedge clk);
    chk("flush_start_busy2", busy, 0);

`ifdef MDU_MADD_EN
    run_op(3'd4, 32'h0, 32'h0, 32'h0, mlo, 0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'd1, 32'd1, 32'd1, 32'h0, MC);
    run_op(3'd7, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, MC);
`else
    run_op(3'd6, 32'd1, 32'd1, mhi, mlo, 0);
    run_op(3'd7, 32'd5, 32'd5, mhi, mlo, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      run_model_op(o, pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
